data_ram_stall: RTL and testbench
=================================

Name: data_ram_stall

Overview:
- Parametrised, byte-lane-writable data RAM for the MEM stage, successor to the single-cycle data RAM.
- Adds a configurable access latency (wait states), a registered read port, a one-cycle completion ack, a stall request to the pipeline controller, and out-of-range address detection.
- The MEM stage holds its request stable while stall_req is high.

Parameters:
- DATA_W, 32, word width in bits; legal values 16, 32, 64. LANES = DATA_W/8; OFF = log2(LANES) (derived localparams).
- ADDR_W, 32, byte-address width.
- DEPTH_LOG2, 17, log2 of word count; the array holds 2^DEPTH_LOG2 words.
- LATENCY, 2, wait cycles between acceptance and commit; legal range 0..7.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  access request.
- we  in  1  1 = write, 0 = read.
- addr  in  ADDR_W  byte address. Word index = addr[DEPTH_LOG2+OFF-1:OFF]; low OFF bits are ignored.
- sel  in  LANES  byte-lane enables; bit i covers data_in[8i+7:8i].
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  registered read data.
- ack  out  1  completion strobe, high for exactly one cycle.
- err  out  1  out-of-range flag, valid only while ack = 1.
- stall_req  out  1  combinational stall request to the pipeline controller.

Behaviour:
- Reset: state = IDLE, data_out = 0, ack = 0, err = 0, counter = 0. Array contents are not initialised or cleared. rst has priority over every other event on the same edge.

- FSM states: IDLE, WAIT, DONE.
  - IDLE: ce = 1 at edge T0 accepts the request. we, addr, sel and data_in are captured.
    - LATENCY = 0: commit at edge T0, go to DONE.
    - Otherwise: counter = LATENCY-1, go to WAIT.
  - WAIT: counter decrements each edge. At the edge where counter = 0, commit and go to DONE. The commit edge is always T0+LATENCY.
  - DONE: ack = 1 and err valid for this one cycle. ce is ignored, because the requester still holds the same request this cycle. Next edge returns to IDLE, so back-to-back accesses are spaced LATENCY+2 cycles apart.

- Commit actions (at the commit edge):
  - Write: for each i with sel[i] = 1, byte lane i of the indexed word is updated from the captured data_in. data_out is set to 0.
  - Read: data_out is set to the full indexed word. sel does not mask read data.
  - sel = 0 write: the array is unchanged, but the access still completes with ack.

- Out-of-range: if any captured addr bit at or above position DEPTH_LOG2+OFF is 1:
  - the write is suppressed and read data_out = 0;
  - err = 1 during the DONE cycle; otherwise err = 0.

- data_out holds its value between completions.

- ack and err are 0 in IDLE and WAIT.

- stall_req = (state == IDLE & ce) | (state == WAIT). It is 0 in DONE, which releases the pipeline in the cycle ack is high.

- Inputs are sampled only at acceptance; changes during WAIT or DONE have no effect.

- Reset mid-operation: if rst is asserted at or before the commit edge, the pending access is abandoned. There is no array update and no ack, and the next state is IDLE.

- Read-after-write to the same word returns the merged new value. There is no forwarding hazard, because the commit precedes any later acceptance.

Test Plan:
1. LATENCY=2, DATA_W=32. Write addr 0x10, sel 4'b1111, data 0xDEADBEEF accepted at edge T0.
   -> stall_req high cycles T0-1..T0+1; ack high only in cycle after edge T0+2; stall_req low in that cycle; err 0.
   Then read 0x10 -> data_out = 0xDEADBEEF with ack.
2. Write 0x11223344 to 0x20. Then write sel 4'b0101, data 0xAABBCCDD to 0x20. Then read 0x20.
   -> 0x11BB33DD.
3. LATENCY=0. Read at edge T0 -> ack in cycle after T0. ce held high through the DONE cycle.
   -> exactly one ack; next acceptance only at edge T0+2.
4. Write addr 0x0008_0000 (DEPTH_LOG2=17, bit 19 set), data 0xFFFFFFFF.
   -> ack with err = 1; word 0 unchanged; read of that address returns data_out 0, err 1.
5. Write 0x55AA55AA to 0x30 accepted; assert rst one cycle before the commit edge.
   -> no ack, state IDLE, data_out 0; subsequent read of 0x30 returns the prior contents.
6. DATA_W=64, LATENCY=7. Write 0x0123456789ABCDEF to addr 0x18, sel 8'hF0; 8'h0F write of 0 beforehand.
   -> read 0x18 gives 0x0123456700000000; ack 8 cycles after acceptance.

Source files
------------

// File: rtl/data_ram_stall.sv
// data_ram_stall: byte-lane-writable data RAM for the MEM stage with a
// configurable access latency, a registered read port, a one-cycle completion
// ack and a stall request back to the pipeline controller.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   ce         access request
//   we         1 = write, 0 = read
//   addr       byte address; word index = addr[DEPTH_LOG2+OFF-1:OFF]
//   sel        byte-lane enables (bit i covers data_in[8i+7:8i])
//   data_in    write data
//   data_out   registered read data (0 after a write or out-of-range access)
//   ack        completion strobe, high for exactly one cycle
//   err        out-of-range flag, meaningful only while ack = 1
//   stall_req  combinational stall request to the pipeline controller
module data_ram_stall #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 17,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   sel,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  ack,
    output logic                  err,
    output logic                  stall_req
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF   = $clog2(LANES);
    localparam int TOP   = DEPTH_LOG2 + OFF;
    localparam logic [2:0] LAT_M1 = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LANES-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;

    // Commit-side view of the request. A commit in IDLE only happens with
    // LATENCY = 0, where the live inputs are the request being accepted.
    logic                c_we;
    logic [ADDR_W-1:0]   c_addr;
    logic [LANES-1:0]    c_sel;
    logic [DATA_W-1:0]   c_data;
    logic                commit;
    logic                oor;
    logic                mem_wr;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]   rd_word;
    logic                unused_lo;

    always_comb begin
        if (state_q == S_IDLE) begin
            c_we   = we;
            c_addr = addr;
            c_sel  = sel;
            c_data = data_in;
        end else begin
            c_we   = we_q;
            c_addr = addr_q;
            c_sel  = sel_q;
            c_data = wdata_q;
        end
    end

    assign oor       = (c_addr >> TOP) != '0;
    assign idx       = c_addr[TOP-1:OFF];
    assign unused_lo = ^c_addr[OFF-1:0];
    // rst on the commit edge abandons the access, including the array write.
    assign mem_wr    = commit & c_we & ~oor & ~rst;

    // One narrow array per byte lane so each lane has a single writer.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] mem [2**DEPTH_LOG2];
        always_ff @(posedge clk) begin
            if (mem_wr && c_sel[i]) begin
                mem[idx] <= c_data[8*i +: 8];
            end
        end
        assign rd_word[8*i +: 8] = mem[idx];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        commit     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ce) begin
                    we_d    = we;
                    addr_d  = addr;
                    sel_d   = sel;
                    wdata_d = data_in;
                    if (LATENCY == 0) begin
                        commit  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    commit  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            // Requester still holds the same request here, so ce is ignored.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // ack/err are registered from the commit so they appear in DONE only.
        if (commit) begin
            ack_d      = 1'b1;
            err_d      = oor;
            data_out_d = (c_we || oor) ? '0 : rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            sel_q      <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign data_out  = data_out_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign stall_req = (state_q == S_IDLE && ce) || (state_q == S_WAIT);
endmodule

// File: tb/tb_data_ram_stall.sv
// Bench for data_ram_stall: three instances (32b/LAT2, 32b/LAT0, 64b/LAT7).
// Stimulus pushes the expected completion into a per-instance queue; monitors
// pop and compare whenever the matching instance raises ack.
module tb_data_ram_stall;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  ce_v, we_v, ack_v, err_v, stall_v;
    logic [31:0] addr [3];
    logic [7:0]  sel  [3];
    logic [63:0] din  [3];
    logic [31:0] do_a, do_z;
    logic [63:0] do_w;

    data_ram_stall #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(17), .LATENCY(2)) u_a (
        .clk(clk), .rst(rst), .ce(ce_v[0]), .we(we_v[0]), .addr(addr[0]),
        .sel(sel[0][3:0]), .data_in(din[0][31:0]), .data_out(do_a),
        .ack(ack_v[0]), .err(err_v[0]), .stall_req(stall_v[0]));

    data_ram_stall #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(17), .LATENCY(0)) u_z (
        .clk(clk), .rst(rst), .ce(ce_v[1]), .we(we_v[1]), .addr(addr[1]),
        .sel(sel[1][3:0]), .data_in(din[1][31:0]), .data_out(do_z),
        .ack(ack_v[1]), .err(err_v[1]), .stall_req(stall_v[1]));

    data_ram_stall #(.DATA_W(64), .ADDR_W(32), .DEPTH_LOG2(17), .LATENCY(7)) u_w (
        .clk(clk), .rst(rst), .ce(ce_v[2]), .we(we_v[2]), .addr(addr[2]),
        .sel(sel[2]), .data_in(din[2]), .data_out(do_w),
        .ack(ack_v[2]), .err(err_v[2]), .stall_req(stall_v[2]));

    typedef struct {
        logic [63:0] d;
        logic        e;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, ex);
        end
    endtask

    task automatic mon(input int d, input logic [63:0] dout, input logic e);
        exp_t x;
        int   n;
        case (d)
            0:       n = q0.size();
            1:       n = q1.size();
            default: n = q2.size();
        endcase
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected ack: data_out %h err %b", d, dout, e);
        end else begin
            case (d)
                0:       x = q0.pop_front();
                1:       x = q1.pop_front();
                default: x = q2.pop_front();
            endcase
            chk($sformatf("dut%0d data_out", d), dout, x.d);
            chk($sformatf("dut%0d err", d), {63'd0, e}, {63'd0, x.e});
        end
    endtask

    always @(negedge clk) begin
        if (ack_v[0]) mon(0, {32'd0, do_a}, err_v[0]);
        if (ack_v[1]) mon(1, {32'd0, do_z}, err_v[1]);
        if (ack_v[2]) mon(2, do_w, err_v[2]);
    end

    // Issue one access on instance d. Called just after a rising edge; ce is
    // held through the DONE cycle and dropped one edge later, so a following
    // call re-raises it before the next edge (back-to-back acceptance).
    task automatic access(input int d, input bit w, input logic [31:0] a,
                          input logic [7:0] s, input logic [63:0] dat,
                          input logic [63:0] ed, input bit ee, input int lat,
                          input string nm);
        exp_t x;
        int   n;
        bit   got;
        ce_v[d] = 1'b1;
        we_v[d] = w;
        addr[d] = a;
        sel[d]  = s;
        din[d]  = dat;
        x.d = ed;
        x.e = ee;
        case (d)
            0:       q0.push_back(x);
            1:       q1.push_back(x);
            default: q2.push_back(x);
        endcase
        #1;
        chk({nm, " stall_req on request"}, {63'd0, stall_v[d]}, 64'd1);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (ack_v[d]) got = 1'b1;
            else chk({nm, " stall_req while pending"}, {63'd0, stall_v[d]}, 64'd1);
        end
        chk({nm, " edges to ack"}, 64'(n), 64'(lat + 1));
        if (got) chk({nm, " stall_req in ack cycle"}, {63'd0, stall_v[d]}, 64'd0);
        @(posedge clk);
        #1;
        ce_v[d] = 1'b0;
        #1;
        chk({nm, " idle after done"}, {63'd0, stall_v[d]}, 64'd0);
    endtask

    initial begin
        rst  = 1'b1;
        ce_v = '0;
        we_v = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            sel[i]  = '0;
            din[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset data_out a", {32'd0, do_a}, 64'd0);
        chk("reset data_out w", do_w, 64'd0);
        chk("reset ack", {61'd0, ack_v}, 64'd0);
        chk("reset err", {61'd0, err_v}, 64'd0);
        chk("reset stall", {61'd0, stall_v}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic write/read, latency 2
        access(0, 1, 32'h10, 8'h0F, 64'hDEADBEEF, 64'h0, 0, 2, "t1 wr");
        access(0, 0, 32'h10, 8'h0F, 64'h0, 64'hDEADBEEF, 0, 2, "t1 rd");

        // Byte-lane merge, then a sel=0 write that must not change the word
        access(0, 1, 32'h20, 8'h0F, 64'h11223344, 64'h0, 0, 2, "t2 wr full");
        access(0, 1, 32'h20, 8'h05, 64'hAABBCCDD, 64'h0, 0, 2, "t2 wr lanes");
        access(0, 0, 32'h20, 8'h0F, 64'h0, 64'h11BB33DD, 0, 2, "t2 rd");
        access(0, 1, 32'h22, 8'h00, 64'hFFFFFFFF, 64'h0, 0, 2, "t2 wr sel0");
        access(0, 0, 32'h23, 8'h00, 64'h0, 64'h11BB33DD, 0, 2, "t2 rd sel0");

        // Zero latency, back-to-back accesses
        access(1, 1, 32'h40, 8'h0F, 64'hCAFEF00D, 64'h0, 0, 0, "t3 wr");
        access(1, 0, 32'h40, 8'h0F, 64'h0, 64'hCAFEF00D, 0, 0, "t3 rd");
        access(1, 0, 32'h41, 8'h01, 64'h0, 64'hCAFEF00D, 0, 0, "t3 rd2");

        // Out-of-range aliasing onto word 0
        access(0, 1, 32'h0, 8'h0F, 64'h12345678, 64'h0, 0, 2, "t4 wr w0");
        access(0, 1, 32'h0008_0000, 8'h0F, 64'hFFFFFFFF, 64'h0, 1, 2, "t4 wr oor");
        access(0, 0, 32'h0, 8'h0F, 64'h0, 64'h12345678, 0, 2, "t4 rd w0");
        access(0, 0, 32'h0008_0000, 8'h0F, 64'h0, 64'h0, 1, 2, "t4 rd oor");

        // Reset one edge before commit abandons the write
        access(0, 1, 32'h30, 8'h0F, 64'h0BADF00D, 64'h0, 0, 2, "t5 pre wr");
        access(0, 0, 32'h30, 8'h0F, 64'h0, 64'h0BADF00D, 0, 2, "t5 pre rd");
        ce_v[0] = 1'b1;
        we_v[0] = 1'b1;
        addr[0] = 32'h30;
        sel[0]  = 8'h0F;
        din[0]  = 64'h55AA55AA;
        @(posedge clk);
        #1;
        ce_v[0] = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5 data_out cleared", {32'd0, do_a}, 64'd0);
        chk("t5 stall after reset", {63'd0, stall_v[0]}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("t5 no ack", {63'd0, ack_v[0]}, 64'd0);
        end
        access(0, 0, 32'h30, 8'h0F, 64'h0, 64'h0BADF00D, 0, 2, "t5 rd");

        // 64-bit, latency 7
        access(2, 1, 32'h18, 8'h0F, 64'h0, 64'h0, 0, 7, "t6 wr lo");
        access(2, 1, 32'h18, 8'hF0, 64'h0123456789ABCDEF, 64'h0, 0, 7, "t6 wr hi");
        access(2, 0, 32'h18, 8'h00, 64'h0, 64'h0123456700000000, 0, 7, "t6 rd");

        repeat (3) @(posedge clk);
        #1;
        chk("pending completions", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
